// File: rtl/maxtest3.sv
// Per-packet unsigned maximum and beat count over an AXI-Stream slave port.
// Optional MAXTEST3_INDEX_EN adds MAX_INDEX, the 0-based position of the first maximum.
module maxtest3 #(
  parameter int STREAM_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET_n,
  output logic                    TREADY,
  input  logic [STREAM_WIDTH-1:0] TDATA,
  input  logic                    TLAST,
  input  logic                    TVALID,
  output logic [STREAM_WIDTH-1:0] MAX_DATA,
  output logic                    MAX_VALID,
  output logic [15:0]             MAX_COUNT
`ifdef MAXTEST3_INDEX_EN
  ,
  output logic [15:0]             MAX_INDEX
`endif
);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t                  state_q, state_d;
  logic                    tready_q, tready_d;
  logic [STREAM_WIDTH-1:0] run_max_q, run_max_d;
  logic [15:0]             count_q, count_d;
  logic [STREAM_WIDTH-1:0] max_data_q, max_data_d;
  logic [15:0]             max_count_q, max_count_d;
  logic                    max_valid_q, max_valid_d;

  logic                    accept;
  logic                    beat_gt;
  logic [STREAM_WIDTH-1:0] beat_max;
  logic [15:0]             beat_cnt;

  // Handshake: a beat transfers on a rising edge where TVALID and TREADY are both 1;
  // TDATA/TLAST are don't-care otherwise. TREADY never drops once out of reset.
  assign accept  = TVALID & tready_q;
  assign beat_gt = TDATA > run_max_q;

`ifdef MAXTEST3_INDEX_EN
  logic [15:0] run_idx_q, run_idx_d;
  logic [15:0] max_index_q, max_index_d;
  logic [15:0] beat_idx;
`endif

  // Running max/count as they stand once the current beat is folded in.
  always_comb begin
    beat_max = TDATA;
    beat_cnt = 16'd1;
`ifdef MAXTEST3_INDEX_EN
    beat_idx = 16'd0;
`endif
    if (state_q == ST_ACCUM) begin
      beat_max = beat_gt ? TDATA : run_max_q;
      beat_cnt = (count_q == CNT_MAX) ? CNT_MAX : count_q + 16'd1;
`ifdef MAXTEST3_INDEX_EN
      // count_q is this beat's position; it saturates together with the count.
      beat_idx = beat_gt ? count_q : run_idx_q;
`endif
    end
  end

  always_comb begin
    tready_d    = 1'b1;
    state_d     = state_q;
    run_max_d   = run_max_q;
    count_d     = count_q;
    max_data_d  = max_data_q;
    max_count_d = max_count_q;
    max_valid_d = 1'b0;
`ifdef MAXTEST3_INDEX_EN
    run_idx_d   = run_idx_q;
    max_index_d = max_index_q;
`endif
    if (accept) begin
      run_max_d = beat_max;
      count_d   = beat_cnt;
`ifdef MAXTEST3_INDEX_EN
      run_idx_d = beat_idx;
`endif
      if (TLAST) begin
        state_d     = ST_FIRST;
        max_valid_d = 1'b1;
        max_data_d  = beat_max;
        max_count_d = beat_cnt;
`ifdef MAXTEST3_INDEX_EN
        max_index_d = beat_idx;
`endif
      end else begin
        state_d = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESET_n) begin
    if (!ARESET_n) begin
      state_q     <= ST_FIRST;
      tready_q    <= 1'b0;
      run_max_q   <= '0;
      count_q     <= '0;
      max_data_q  <= '0;
      max_count_q <= '0;
      max_valid_q <= 1'b0;
`ifdef MAXTEST3_INDEX_EN
      run_idx_q   <= '0;
      max_index_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      run_max_q   <= run_max_d;
      count_q     <= count_d;
      max_data_q  <= max_data_d;
      max_count_q <= max_count_d;
      max_valid_q <= max_valid_d;
`ifdef MAXTEST3_INDEX_EN
      run_idx_q   <= run_idx_d;
      max_index_q <= max_index_d;
`endif
    end
  end

  assign TREADY    = tready_q;
  assign MAX_DATA  = max_data_q;
  assign MAX_COUNT = max_count_q;
  assign MAX_VALID = max_valid_q;
`ifdef MAXTEST3_INDEX_EN
  assign MAX_INDEX = max_index_q;
`endif

endmodule

// File: tb/tb_maxtest3.sv
// Bench for maxtest3: vector table, hand sequences, long saturating packet and random traffic
// checked cycle by cycle against a packet-level model (MAXTEST3_INDEX_EN adds index checks).
module tb_maxtest3;
  localparam int W = 32;

  logic          ACLK     = 1'b0;
  logic          ARESET_n = 1'b1;
  logic          TREADY;
  logic [W-1:0]  TDATA    = '0;
  logic          TLAST    = 1'b0;
  logic          TVALID   = 1'b0;
  logic [W-1:0]  MAX_DATA;
  logic          MAX_VALID;
  logic [15:0]   MAX_COUNT;
`ifdef MAXTEST3_INDEX_EN
  logic [15:0]   MAX_INDEX;
`endif

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  maxtest3 #(.STREAM_WIDTH(W)) dut (
    .ACLK      (ACLK),
    .ARESET_n  (ARESET_n),
    .TREADY    (TREADY),
    .TDATA     (TDATA),
    .TLAST     (TLAST),
    .TVALID    (TVALID),
    .MAX_DATA  (MAX_DATA),
    .MAX_VALID (MAX_VALID),
    .MAX_COUNT (MAX_COUNT)
`ifdef MAXTEST3_INDEX_EN
    ,
    .MAX_INDEX (MAX_INDEX)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] pkt_q[$];
  logic [W-1:0] exp_q[$];
  logic         exp_tready = 1'b0;
  logic         exp_mv     = 1'b0;
  logic [W-1:0] exp_md     = '0;
  logic [15:0]  exp_mc     = '0;
  logic [15:0]  exp_mi     = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pkt_q.delete();
    exp_tready = 1'b0;
    exp_mv     = 1'b0;
    exp_md     = '0;
    exp_mc     = '0;
    exp_mi     = '0;
  endtask

  task automatic model_complete();
    logic [W-1:0] m;
    int           m_idx;
    m     = pkt_q[0];
    m_idx = 0;
    for (int i = 1; i < pkt_q.size(); i++) begin
      if (pkt_q[i] > m) begin
        m     = pkt_q[i];
        m_idx = i;
      end
    end
    exp_mv = 1'b1;
    exp_md = m;
    exp_mc = (pkt_q.size() > 65535) ? 16'hFFFF : 16'(pkt_q.size());
    exp_mi = (m_idx > 65535) ? 16'hFFFF : 16'(m_idx);
    exp_q.push_back(m);
    pkt_q.delete();
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic l);
    exp_mv = 1'b0;
    if (!ARESET_n) begin
      model_reset();
    end else begin
      if (v && exp_tready) begin
        pkt_q.push_back(d);
        if (l) model_complete();
      end
      exp_tready = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    chk("tready", TREADY, exp_tready);
    chk("max_valid", MAX_VALID, exp_mv);
    chk("max_data", MAX_DATA, exp_md);
    chk("max_count", MAX_COUNT, exp_mc);
`ifdef MAXTEST3_INDEX_EN
    chk("max_index", MAX_INDEX, exp_mi);
`endif
    if (MAX_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_pulse: got pulse with data %0h, expected no pulse", MAX_DATA);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", MAX_DATA, e);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [W-1:0] d, input logic l);
    TVALID = v;
    TDATA  = d;
    TLAST  = l;
    @(posedge ACLK);
    model_edge(v, d, l);
    @(negedge ACLK);
    check_outputs();
  endtask

  task automatic check_async_reset();
    #2 ARESET_n = 1'b0;
    #1;
    model_reset();
    chk("rst_tready", TREADY, 1'b0);
    chk("rst_valid", MAX_VALID, 1'b0);
    chk("rst_data", MAX_DATA, '0);
    chk("rst_count", MAX_COUNT, 16'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        mv;
    logic [31:0] md;
    logic [15:0] mc;
    logic [15:0] mi;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l, input logic mv,
                              input logic [31:0] md, input logic [15:0] mc, input logic [15:0] mi);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.mv = mv; r.md = md; r.mc = mc; r.mi = mi;
    return r;
  endfunction

  vec_t vecs[17];

  initial begin
    logic         rv, rl;
    logic [W-1:0] rd;

    vecs[0]  = mk(1, 5,     0, 0, 0,     0, 0);
    vecs[1]  = mk(1, 900,   0, 0, 0,     0, 0);
    vecs[2]  = mk(1, 17,    0, 0, 0,     0, 0);
    vecs[3]  = mk(1, 900,   1, 1, 900,   4, 1);
    vecs[4]  = mk(0, 0,     0, 0, 900,   4, 1);
    vecs[5]  = mk(1, 42,    1, 1, 42,    1, 0);
    vecs[6]  = mk(1, 3,     0, 0, 42,    1, 0);
    vecs[7]  = mk(1, 65000, 1, 1, 65000, 2, 1);
    vecs[8]  = mk(1, 7,     1, 1, 7,     1, 0);
    vecs[9]  = mk(1, 10,    0, 0, 7,     1, 0);
    vecs[10] = mk(0, 99,    1, 0, 7,     1, 0);
    vecs[11] = mk(0, 0,     0, 0, 7,     1, 0);
    vecs[12] = mk(0, 0,     0, 0, 7,     1, 0);
    vecs[13] = mk(1, 20,    1, 1, 20,    2, 1);
    vecs[14] = mk(0, 0,     0, 0, 20,    2, 1);
    vecs[15] = mk(1, 8,     0, 0, 20,    2, 1);
    vecs[16] = mk(1, 8,     1, 1, 8,     2, 0);

    // Reset entry and release
    #1 ARESET_n = 1'b0;
    #1;
    chk("por_tready", TREADY, 1'b0);
    chk("por_valid", MAX_VALID, 1'b0);
    chk("por_data", MAX_DATA, '0);
    chk("por_count", MAX_COUNT, 16'd0);
    model_reset();
    step(1, 32'd55, 1'b1);
    step(0, '0, 1'b0);
    ARESET_n = 1'b1;
    // The beat offered on the first edge after release must be ignored.
    step(1, 32'd77, 1'b1);
    step(0, '0, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].l);
      chk($sformatf("vec%0d_valid", i), MAX_VALID, vecs[i].mv);
      chk($sformatf("vec%0d_data", i), MAX_DATA, vecs[i].md);
      chk($sformatf("vec%0d_count", i), MAX_COUNT, vecs[i].mc);
`ifdef MAXTEST3_INDEX_EN
      chk($sformatf("vec%0d_index", i), MAX_INDEX, vecs[i].mi);
`endif
    end

    // Reset in the middle of a packet discards it
    step(1, 32'd100, 1'b0);
    step(1, 32'd200, 1'b0);
    check_async_reset();
    step(1, 32'd300, 1'b1);
    step(1, 32'd400, 1'b1);
    ARESET_n = 1'b1;
    step(0, '0, 1'b0);
    step(1, 32'd1, 1'b1);
    chk("abort_data", MAX_DATA, 32'd1);
    chk("abort_count", MAX_COUNT, 16'd1);
    chk("abort_valid", MAX_VALID, 1'b1);
    step(0, '0, 1'b0);

    // 65537-beat packet: count and index saturate, comparison keeps running
    for (int i = 0; i <= 65536; i++) begin
      if (i == 65536) step(1, 32'd5000, 1'b1);
      else            step(1, W'($urandom_range(0, 999)), 1'b0);
    end
    chk("sat_count", MAX_COUNT, 16'hFFFF);
    chk("sat_data", MAX_DATA, 32'd5000);
`ifdef MAXTEST3_INDEX_EN
    chk("sat_index", MAX_INDEX, 16'hFFFF);
`endif
    step(0, '0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        check_async_reset();
        step(1, W'($urandom), 1'b0);
        ARESET_n = 1'b1;
      end
      rv = ($urandom_range(0, 9) < 7);
      rd = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 15));
      rl = ($urandom_range(0, 5) == 0);
      step(rv, rd, rl);
    end
    step(0, '0, 1'b0);
    step(0, '0, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maxtest3.md
MAXTEST3 -- requirements
Module: maxtest3

Interface
REQ-001 Parameter STREAM_WIDTH, default 32: width of TDATA and MAX_DATA in bits; legal range 8..64.
REQ-002 ACLK  input  1  single clock; all state changes on its rising edge.
REQ-003 ARESET_n  input  1  reset; asynchronous assert, active-low.
REQ-004 TREADY  output  1  AXI-Stream slave ready.
REQ-005 TDATA  input  STREAM_WIDTH  AXI-Stream data word, unsigned.
REQ-006 TLAST  input  1  marks the last beat of a packet.
REQ-007 TVALID  input  1  AXI-Stream data valid.
REQ-008 MAX_DATA  output  STREAM_WIDTH  maximum of the most recently completed packet.
REQ-009 MAX_VALID  output  1  one-cycle pulse; MAX_DATA, MAX_COUNT (and MAX_INDEX) updated this cycle.
REQ-010 MAX_COUNT  output  16  number of beats in the most recently completed packet.
REQ-011 Positional port order is ACLK, ARESET_n, TREADY, TDATA, TLAST, TVALID, MAX_DATA, MAX_VALID, MAX_COUNT; MAX_INDEX, when present, is last.

Function
REQ-012 A beat is accepted only on a rising edge where TVALID=1 and TREADY=1; TDATA/TLAST are ignored otherwise.
REQ-013 TREADY is registered: 0 in reset, 1 from the first rising edge after ARESET_n deasserts, then stays 1 with no backpressure.
REQ-014 State FSM: FIRST (next accepted beat opens a packet) and ACCUM (packet in progress); reset state is FIRST.
REQ-015 In FIRST, an accepted beat loads the running max with TDATA and the beat count with 1, then moves to ACCUM, unless TLAST=1.
REQ-016 In ACCUM, an accepted beat replaces the running max only if TDATA is strictly greater (unsigned), and increments the beat count.
REQ-017 Beat count saturates at 65535; the comparison continues after saturation.
REQ-018 An accepted beat with TLAST=1 in either state completes the packet and returns the FSM to FIRST.
REQ-019 On completion, the next edge registers MAX_DATA = max over all beats including the TLAST beat, MAX_COUNT = final count, and MAX_VALID = 1; latency is 1 cycle from the TLAST beat.
REQ-020 MAX_VALID is high for exactly one cycle per packet; MAX_DATA/MAX_COUNT hold their values until the next completion.
REQ-021 A single-beat packet (TLAST on the first beat) yields MAX_DATA = that beat and MAX_COUNT = 1.
REQ-022 Back-to-back packets with no idle cycle are supported; a beat following a TLAST beat opens a new packet.
REQ-023 Idle cycles (TVALID=0) inside a packet leave all state unchanged.

Reset
REQ-024 While ARESET_n=0: TREADY=0, MAX_VALID=0, MAX_DATA=0, MAX_COUNT=0, MAX_INDEX=0, running max=0, count=0, FSM=FIRST.
REQ-025 Reset asserted mid-packet discards the partial packet; no MAX_VALID pulse is produced for it.

Configuration
REQ-026 Macro MAXTEST3_INDEX_EN defined: adds output MAX_INDEX [15:0] giving the 0-based beat position of the first occurrence of the maximum; it updates with MAX_DATA and saturates at 65535.
REQ-027 Macro MAXTEST3_INDEX_EN undefined: no MAX_INDEX port and no index logic; all other behaviour is identical.

Verification
REQ-028 Reset release: TREADY=0 during reset, 1 one edge after release; MAX_VALID=0 throughout.
REQ-029 Packet 5, 900, 17, 900(TLAST) -> one cycle later MAX_DATA=900, MAX_COUNT=4, MAX_VALID pulses once, MAX_INDEX=1.
REQ-030 Single beat 42 with TLAST -> MAX_DATA=42, MAX_COUNT=1, MAX_INDEX=0.
REQ-031 Back-to-back packets {3,65000(TLAST)} then {7(TLAST)} with TVALID held high -> pulses with 65000/2 then 7/1 on consecutive completions.
REQ-032 Packet 10, TVALID=0 for 3 cycles, 20(TLAST) -> MAX_DATA=20, MAX_COUNT=2.
REQ-033 ARESET_n pulsed low after beats 100, 200 and before TLAST; new packet 1(TLAST) -> no pulse for the aborted packet; MAX_DATA=1, MAX_COUNT=1.
